// File: rtl/leds_racer_pkg.sv
// ----------------------------------------------------------------------------
// leds_racer_pkg
// Shared types and default timing for the LED racer strip serialiser.
//   grb_t        : 24-bit packed pixel, G in [23:16], R in [15:8], B in [7:0]
//   tx_state_t   : frame transmitter states
//   DEF_*        : default cycle counts for a 50 MHz chip clock
//   max_int      : constant helper used to size shared counters
// ----------------------------------------------------------------------------
package leds_racer_pkg;

    typedef struct packed {
        logic [7:0] g;
        logic [7:0] r;
        logic [7:0] b;
    } grb_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        BIT   = 2'd2,
        LATCH = 2'd3
    } tx_state_t;

    localparam int BITS_PER_PIXEL = 24;

    localparam int DEF_NUM_LEDS = 109;
    localparam int DEF_T_BIT    = 63;
    localparam int DEF_T0H      = 20;
    localparam int DEF_T1H      = 40;
    localparam int DEF_T_LATCH  = 3000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ws2812_bit_timer.sv
// ----------------------------------------------------------------------------
// ws2812_bit_timer
// Generates one WS2812 bit cell at a time: cell counter 0..T_BIT-1 and the
// registered line level (high while counter < T1H for a 1, < T0H for a 0).
// Ports:
//   clk, rst_n : clock, async active-low reset
//   go         : cells run in the next cycle (a fresh cell starts when the
//                timer was not running, or the current cell is ending)
//   bit_val    : value of the bit in the current cell (stable within a cell)
//   line       : registered line level
//   cell_end   : high during the last cycle of a cell
// ----------------------------------------------------------------------------
module ws2812_bit_timer
    import leds_racer_pkg::*;
#(
    parameter int T_BIT = DEF_T_BIT,
    parameter int T0H   = DEF_T0H,
    parameter int T1H   = DEF_T1H,
    parameter int CNT_W = $clog2(T_BIT + 1)
)(
    input  logic clk,
    input  logic rst_n,
    input  logic go,
    input  logic bit_val,
    output logic line,
    output logic cell_end
);

    localparam logic [CNT_W-1:0] CELL_LAST = CNT_W'(T_BIT - 1);
    localparam logic [CNT_W-1:0] T0H_C     = CNT_W'(T0H);
    localparam logic [CNT_W-1:0] T1H_C     = CNT_W'(T1H);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] thresh;
    logic             active_q;

    assign thresh   = bit_val ? T1H_C : T0H_C;
    assign cnt_inc  = cnt_q + 1'b1;
    assign cell_end = active_q && (cnt_q == CELL_LAST);

    // line is computed for the counter value of the next cycle so that the
    // registered level lines up with the cell counter; every cell opens high
    // because T0H > 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            line     <= 1'b0;
            active_q <= 1'b0;
        end else begin
            active_q <= go;
            if (!go) begin
                cnt_q <= '0;
                line  <= 1'b0;
            end else if (!active_q || cnt_q == CELL_LAST) begin
                cnt_q <= '0;
                line  <= 1'b1;
            end else begin
                cnt_q <= cnt_inc;
                line  <= (cnt_inc < thresh);
            end
        end
    end

endmodule

// File: rtl/ws2812_frame_tx.sv
// ----------------------------------------------------------------------------
// ws2812_frame_tx
// Serialises NUM_LEDS GRB pixels (fetched by index) onto a WS2812 data line,
// MSB first, then holds the line low for T_LATCH cycles.
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   start       : single-cycle frame request (ignored while busy)
//   led_idx     : index of the pixel requested from the frame source
//   led_grb     : colour of pixel led_idx
//   busy        : high from accepted start until after frame_done
//   frame_done  : one-cycle pulse on the last latch cycle
//   leds_line   : registered WS2812 data line
// Build option: define WS2812_AUTO_REFRESH_EN for continuous back-to-back
// frames from reset release (start ignored, busy stays high).
//
// state | meaning
// IDLE  | line low, led_idx 0, waiting for start
// FETCH | one cycle, pixel 0 loaded into the shift register at its end
// BIT   | bit cells running; next pixel loaded on the 24th cell end
// LATCH | line low for T_LATCH cycles, frame_done on the last one
// ----------------------------------------------------------------------------
module ws2812_frame_tx
    import leds_racer_pkg::*;
#(
    parameter int NUM_LEDS = DEF_NUM_LEDS,
    parameter int T_BIT    = DEF_T_BIT,
    parameter int T0H      = DEF_T0H,
    parameter int T1H      = DEF_T1H,
    parameter int T_LATCH  = DEF_T_LATCH,
    parameter int IDX_W    = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [IDX_W-1:0] led_idx,
    input  grb_t             led_grb,
    output logic             busy,
    output logic             frame_done,
    output logic             leds_line
);

`ifdef WS2812_AUTO_REFRESH_EN
    localparam bit AUTO_REFRESH = 1'b1;
`else
    localparam bit AUTO_REFRESH = 1'b0;
`endif

    localparam int CNT_W = $clog2(max_int(T_BIT, T_LATCH) + 1);
    localparam int PIX_W = $clog2(NUM_LEDS + 1);

    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_LEDS - 1);
    localparam logic [PIX_W-1:0] PIX_TOTAL  = PIX_W'(NUM_LEDS);
    localparam logic [4:0]       BIT_LAST   = 5'(BITS_PER_PIXEL - 1);
    localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(T_LATCH - 1);
    localparam logic [CNT_W-1:0] LATCH_ONE  = CNT_W'(1);

    tx_state_t        state;
    logic [23:0]      shift_q;
    logic [4:0]       bit_cnt_q;
    logic [PIX_W-1:0] pix_cnt_q;
    logic [CNT_W-1:0] latch_cnt_q;

    logic             cell_end;
    logic             last_cell;
    logic             timer_go;
    logic             accept;
    logic [IDX_W-1:0] idx_next;

    // In auto-refresh builds every IDLE cycle behaves as if start were high.
    assign accept    = AUTO_REFRESH | start;
    assign idx_next  = (led_idx == IDX_LAST) ? IDX_LAST : led_idx + 1'b1;
    assign last_cell = cell_end && (bit_cnt_q == BIT_LAST) && (pix_cnt_q == PIX_TOTAL);
    assign timer_go  = (state == FETCH) || ((state == BIT) && !last_cell);

    ws2812_bit_timer #(
        .T_BIT (T_BIT),
        .T0H   (T0H),
        .T1H   (T1H),
        .CNT_W (CNT_W)
    ) u_bit_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .go       (timer_go),
        .bit_val  (shift_q[23]),
        .line     (leds_line),
        .cell_end (cell_end)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            pix_cnt_q   <= '0;
            latch_cnt_q <= '0;
            led_idx     <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    led_idx    <= '0;
                    frame_done <= 1'b0;
                    if (accept) begin
                        state <= FETCH;
                        busy  <= 1'b1;
                    end
                end

                FETCH: begin
                    shift_q   <= led_grb;
                    bit_cnt_q <= '0;
                    pix_cnt_q <= PIX_W'(1);
                    led_idx   <= idx_next;
                    state     <= BIT;
                end

                BIT: begin
                    if (cell_end) begin
                        if (bit_cnt_q != BIT_LAST) begin
                            shift_q   <= {shift_q[22:0], 1'b0};
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end else if (pix_cnt_q < PIX_TOTAL) begin
                            // next pixel follows with no gap
                            shift_q   <= led_grb;
                            bit_cnt_q <= '0;
                            pix_cnt_q <= pix_cnt_q + 1'b1;
                            led_idx   <= idx_next;
                        end else begin
                            state       <= LATCH;
                            latch_cnt_q <= LATCH_LAST;
                            frame_done  <= (T_LATCH == 1);
                        end
                    end
                end

                LATCH: begin
                    if (latch_cnt_q == '0) begin
                        frame_done <= 1'b0;
                        led_idx    <= '0;
                        busy       <= AUTO_REFRESH;
                        state      <= AUTO_REFRESH ? FETCH : IDLE;
                    end else begin
                        latch_cnt_q <= latch_cnt_q - 1'b1;
                        frame_done  <= (latch_cnt_q == LATCH_ONE);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
